// File: rtl/sequential_divider_pkg.sv
// Shared constants for the sequential restoring divider: state encoding and default widths.
package seq_div_pkg;

  localparam int STATE_W            = 2;
  localparam int DEF_DIVIDEND_WIDTH = 12;
  localparam int DEF_DIVISOR_WIDTH  = 4;
  localparam int DEF_CNT_WIDTH      = 4;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE    = 2'd2,
    DISPLAY = 2'd3
  } state_t;

endpackage

// File: rtl/sequential_divider_if.sv
// Command/result bus of the sequential divider; master drives commands, slave is the divider.
interface sequential_divider_if #(
  parameter int DIVIDEND_WIDTH = 12,
  parameter int DIVISOR_WIDTH  = 4
) ();

  // Commands are level strobes sampled on every rising clk edge; there is no ready.
  // Priority when several are high in IDLE/DISPLAY is write > divide > display, and
  // all of them are ignored while busy is high or done is pulsing.
  logic [DIVIDEND_WIDTH-1:0] dividend;
  logic [DIVISOR_WIDTH-1:0]  divisor;
  logic                      write;
  logic                      divide;
  logic                      display;
  logic                      busy;
  logic                      done;
  logic                      div_by_zero;
  logic [DIVIDEND_WIDTH-1:0] out;
  logic [DIVISOR_WIDTH-1:0]  rem_out;

  modport master (
    output dividend, divisor, write, divide, display,
    input  busy, done, div_by_zero, out, rem_out
  );

  modport slave (
    input  dividend, divisor, write, divide, display,
    output busy, done, div_by_zero, out, rem_out
  );

endinterface

// File: rtl/sequential_divider_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit, subtract if it fits.
module div_step #(
  parameter int DIVISOR_WIDTH = 4
) (
  input  logic [DIVISOR_WIDTH-1:0] r_in,
  input  logic                     q_msb,
  input  logic [DIVISOR_WIDTH-1:0] divisor,
  output logic [DIVISOR_WIDTH-1:0] r_out,
  output logic                     q_bit
);

  logic [DIVISOR_WIDTH:0] r_shift;
  logic [DIVISOR_WIDTH:0] r_diff;

  assign r_shift = {r_in, q_msb};
  assign r_diff  = r_shift - {1'b0, divisor};

  // A restored remainder is always below the divisor, so its top bit is zero in both branches.
  always_comb begin
    q_bit = (r_shift >= {1'b0, divisor});
    r_out = q_bit ? r_diff[DIVISOR_WIDTH-1:0] : r_shift[DIVISOR_WIDTH-1:0];
  end

endmodule

// File: rtl/sequential_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Optional SEQ_DIV_ZERO_CHECK_EN: short-circuit zero divisors and raise div_by_zero.
module sequential_divider
  import seq_div_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = DEF_DIVIDEND_WIDTH,
  parameter int DIVISOR_WIDTH  = DEF_DIVISOR_WIDTH,
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sequential_divider_if.slave   bus,
  output state_t                state_dbg
);

  state_t                    state_q;
  logic [DIVIDEND_WIDTH-1:0] a_q;
  logic [DIVISOR_WIDTH-1:0]  b_q;
  logic [DIVISOR_WIDTH-1:0]  r_q;
  logic [DIVIDEND_WIDTH-1:0] q_q;
  logic [CNT_WIDTH-1:0]      cnt_q;
  logic [DIVIDEND_WIDTH-1:0] quot_q;
  logic [DIVISOR_WIDTH-1:0]  rem_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      dbz_q;

  logic [DIVISOR_WIDTH-1:0]  r_nxt;
  logic                      q_bit;
  logic [DIVIDEND_WIDTH-1:0] q_shift;
  logic                      last_iter;
  logic                      zero_skip;

  div_step #(
    .DIVISOR_WIDTH (DIVISOR_WIDTH)
  ) u_step (
    .r_in    (r_q),
    .q_msb   (q_q[DIVIDEND_WIDTH-1]),
    .divisor (b_q),
    .r_out   (r_nxt),
    .q_bit   (q_bit)
  );

  assign q_shift   = {q_q[DIVIDEND_WIDTH-2:0], q_bit};
  assign last_iter = (cnt_q == CNT_WIDTH'(DIVIDEND_WIDTH - 1));

`ifdef SEQ_DIV_ZERO_CHECK_EN
  assign zero_skip = (b_q == '0);
`else
  assign zero_skip = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DISPLAY: begin
          if (bus.write) begin
            a_q     <= bus.dividend;
            b_q     <= bus.divisor;
            state_q <= IDLE;
          end else if (bus.divide) begin
            r_q     <= '0;
            q_q     <= a_q;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else if (bus.display) begin
            state_q <= DISPLAY;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          if (zero_skip) begin
            quot_q  <= '1;
            rem_q   <= '0;
            dbz_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            r_q   <= r_nxt;
            q_q   <= q_shift;
            cnt_q <= cnt_q + 1'b1;
            if (last_iter) begin
              quot_q  <= q_shift;
              rem_q   <= r_nxt;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.out     = (state_q == DISPLAY) ? quot_q : '0;
  assign bus.rem_out = (state_q == DISPLAY) ? rem_q : '0;
  assign state_dbg   = state_q;

`ifdef SEQ_DIV_ZERO_CHECK_EN
  assign bus.div_by_zero = dbz_q;
`else
  // Without the zero check the flag register is never set; the output is a hard zero.
  assign bus.div_by_zero = 1'b0 & dbz_q;
`endif

endmodule

// File: tb/tb_sequential_divider.sv
// Scoreboard bench for sequential_divider: random operands checked against an arithmetic model.
module tb_sequential_divider;
  import seq_div_pkg::*;

  localparam int DW = 12;
  localparam int VW = 4;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_t state_dbg;

  always #5 clk = ~clk;

  sequential_divider_if #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(VW)) bus ();

  sequential_divider #(
    .DIVIDEND_WIDTH (DW),
    .DIVISOR_WIDTH  (VW),
    .CNT_WIDTH      (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  int checks = 0;
  int failures = 0;

  // scoreboard queues: done events {div_by_zero, busy cycles} and displayed {quotient, remainder}
  logic [5:0]       exp_q[$];
  logic [DW+VW-1:0] res_q[$];

  // reference model state: operands last written, results of last completed division
  logic [DW-1:0] lat_a = '0;
  logic [VW-1:0] lat_b = '0;
  logic [DW-1:0] res_quot = '0;
  logic [VW-1:0] res_rem = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // {div_by_zero, quotient, remainder} straight from integer division
  function automatic logic [DW+VW:0] model(input logic [DW-1:0] a, input logic [VW-1:0] b);
    logic [DW-1:0] q;
    logic [DW-1:0] r;
    if (b != 0) begin
      q = a / DW'(b);
      r = a % DW'(b);
      return {1'b0, q, r[VW-1:0]};
    end
`ifdef SEQ_DIV_ZERO_CHECK_EN
    return {1'b1, {DW{1'b1}}, {VW{1'b0}}};
`else
    return {1'b0, {DW{1'b1}}, a[VW-1:0]};
`endif
  endfunction

  function automatic bit zero_fast(input logic [VW-1:0] b);
`ifdef SEQ_DIV_ZERO_CHECK_EN
    return (b == '0);
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- monitor ----------------
  logic             disp_seen = 1'b0;
  int               busy_cnt = 0;
  logic [5:0]       mon_e;
  logic [DW+VW-1:0] mon_r;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) disp_seen <= 1'b0;
    else        disp_seen <= bus.display && !bus.write && !bus.divide;

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_done: got done=1, expected no pending division");
        end else begin
          mon_e = exp_q.pop_front();
          check("div_by_zero", 32'(bus.div_by_zero), 32'(mon_e[5]));
          check("busy_cycles", busy_cnt, 32'(mon_e[4:0]));
        end
        busy_cnt = 0;
      end
      if (disp_seen) begin
        if (res_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_display: got display cycle, expected none pending");
        end else begin
          mon_r = res_q.pop_front();
          check("out", 32'(bus.out), 32'(mon_r[DW+VW-1:VW]));
          check("rem_out", 32'(bus.rem_out), 32'(mon_r[VW-1:0]));
        end
      end
    end
  end

  // ---------------- drivers (enter and leave on a negedge) ----------------
  task automatic do_write(input logic [DW-1:0] a, input logic [VW-1:0] b);
    bus.write = 1'b1;
    bus.dividend = a;
    bus.divisor = b;
    lat_a = a;
    lat_b = b;
    @(negedge clk);
    bus.write = 1'b0;
  endtask

  // current negedge is cycle 1 after the divide was sampled; returns on the done cycle
  task automatic wait_done(input bit inject, input int lat_exp);
    int k;
    bit seen;
    k = 1;
    seen = 1'b0;
    while (k <= 30 && !seen) begin
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        if (inject) begin
          case (k)
            2: begin bus.write = 1'b1; bus.dividend = 12'd50; bus.divisor = 4'd3; end
            3: bus.write = 1'b0;
            4: bus.divide = 1'b1;
            5: bus.divide = 1'b0;
            default: ;
          endcase
        end
        @(negedge clk);
        k++;
      end
    end
    check("done_latency", seen ? k : 0, lat_exp);
  endtask

  task automatic push_divide();
    logic [DW+VW:0] m;
    m = model(lat_a, lat_b);
    exp_q.push_back({m[DW+VW], zero_fast(lat_b) ? 5'd1 : 5'd12});
    res_quot = m[DW+VW-1:VW];
    res_rem = m[VW-1:0];
  endtask

  task automatic do_divide(input bit inject);
    int lat;
    lat = zero_fast(lat_b) ? 2 : 13;
    bus.divide = 1'b1;
    push_divide();
    @(negedge clk);
    bus.divide = 1'b0;
    wait_done(inject, lat);
    @(negedge clk);
  endtask

  task automatic do_display();
    res_q.push_back({res_quot, res_rem});
    res_q.push_back({res_quot, res_rem});
    bus.display = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.display = 1'b0;
    @(negedge clk);
    check("out_after_display", 32'(bus.out), 0);
    check("rem_after_display", 32'(bus.rem_out), 0);
  endtask

  task automatic run_case(input logic [DW-1:0] a, input logic [VW-1:0] b);
    do_write(a, b);
    do_divide(1'b0);
    do_display();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.dividend = '0;
    bus.divisor = '0;
    bus.write = 1'b0;
    bus.divide = 1'b0;
    bus.display = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 0);
    check("reset_done", 32'(bus.done), 0);
    check("reset_dbz", 32'(bus.div_by_zero), 0);
    check("reset_out", 32'(bus.out), 0);
    check("reset_rem", 32'(bus.rem_out), 0);
    check("reset_state", 32'(state_dbg), 32'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // directed cases from the plan
    run_case(12'd100, 4'd7);
    run_case(12'd4095, 4'd1);
    run_case(12'd5, 4'd9);
    run_case(12'd200, 4'd0);
    run_case(12'd0, 4'd15);

    // commands during RUN are ignored; operands stay latched for a later divide
    do_write(12'd100, 4'd7);
    do_divide(1'b1);
    do_display();
    do_divide(1'b0);
    do_display();

    // back-to-back: divide held through DONE restarts from IDLE
    do_write(12'd1000, 4'd9);
    bus.divide = 1'b1;
    push_divide();
    @(negedge clk);
    wait_done(1'b0, 13);
    push_divide();
    @(negedge clk);
    check("b2b_idle_busy", 32'(bus.busy), 0);
    check("b2b_idle_state", 32'(state_dbg), 32'(IDLE));
    @(negedge clk);
    check("b2b_restart_busy", 32'(bus.busy), 1);
    bus.divide = 1'b0;
    wait_done(1'b0, 13);
    @(negedge clk);
    do_display();

    // reset in the middle of RUN
    do_write(12'd100, 4'd7);
    bus.divide = 1'b1;
    exp_q.push_back(6'd12);
    @(negedge clk);
    bus.divide = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    void'(exp_q.pop_back());
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_done", 32'(bus.done), 0);
    check("abort_out", 32'(bus.out), 0);
    check("abort_rem", 32'(bus.rem_out), 0);
    check("abort_state", 32'(state_dbg), 32'(IDLE));
    lat_a = '0;
    lat_b = '0;
    res_quot = '0;
    res_rem = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_display();

    // all three commands together: only the write takes effect
    bus.write = 1'b1;
    bus.divide = 1'b1;
    bus.display = 1'b1;
    bus.dividend = 12'd33;
    bus.divisor = 4'd5;
    lat_a = 12'd33;
    lat_b = 4'd5;
    @(negedge clk);
    bus.write = 1'b0;
    bus.divide = 1'b0;
    bus.display = 1'b0;
    check("combo_state", 32'(state_dbg), 32'(IDLE));
    check("combo_busy", 32'(bus.busy), 0);
    check("combo_out", 32'(bus.out), 0);
    @(negedge clk);
    check("combo_busy_later", 32'(bus.busy), 0);
    do_divide(1'b0);
    do_display();

    // random operands, divisor zero included in the range
    for (int i = 0; i < 24; i++) begin
      run_case(DW'($urandom_range(0, 4095)), VW'($urandom_range(0, 15)));
    end

    repeat (3) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("res_q_drained", res_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion, expected finish before 200000");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
